cordic_vec_stream_ctrl: RTL and testbench

//  Flow-control sequencer between an AXI-Stream source of packed X/Y samples and the

---
 rtl/cordic_ctrl_pkg.sv | 20 ++
 rtl/cordic_result_fifo.sv | 45 ++++
 rtl/cordic_vec_stream_ctrl.sv | 113 +++++++++++
 tb/tb_cordic_vec_stream_ctrl.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cordic_ctrl_pkg.sv
// cordic_ctrl_pkg: shared widths, result record and stream pack/unpack helpers for the CORDIC stream controller.
package cordic_ctrl_pkg;
    localparam int XY_W    = 12;
    localparam int AMP_W   = 12;
    localparam int PH_W    = 14;
    localparam int TDATA_W = 32;

    typedef struct packed {
        logic [AMP_W-1:0] amp;
        logic [PH_W-1:0]  phase;
    } result_t;

    function automatic logic [2*XY_W-1:0] unpack_xy(input logic [TDATA_W-1:0] d);
        return {d[27:16], d[11:0]};
    endfunction

    function automatic logic [TDATA_W-1:0] pack_result(input result_t r);
        return {4'd0, r.amp, 2'd0, r.phase};
    endfunction
endpackage

// File: rtl/cordic_result_fifo.sv
// cordic_result_fifo: synchronous result buffer; the caller never pushes when full unless popping in the same cycle.
module cordic_result_fifo
    import cordic_ctrl_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic                   i_push,
    input  result_t                i_data,
    input  logic                   i_pop,
    output result_t                o_data,
    output logic                   o_full,
    output logic                   o_empty,
    output logic [$clog2(DEPTH):0] o_count
);
    localparam int AW = $clog2(DEPTH);

    result_t        r_mem [DEPTH];
    logic [AW-1:0]  r_wr;
    logic [AW-1:0]  r_rd;
    logic [AW:0]    r_count;

    assign o_data  = r_mem[r_rd];
    assign o_empty = r_count == '0;
    assign o_full  = r_count == (AW+1)'(DEPTH);
    assign o_count = r_count;

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
        end else begin
            if (i_push) r_wr <= r_wr + AW'(1);
            if (i_pop) r_rd <= r_rd + AW'(1);
            r_count <= r_count + (AW+1)'(i_push) - (AW+1)'(i_pop);
        end
    end

    // A push into a full buffer lands in the slot being popped; the read is combinational so the old head leaves first.
    always_ff @(posedge CLK) begin
        if (i_push) r_mem[r_wr] <= i_data;
    end
endmodule

// File: rtl/cordic_vec_stream_ctrl.sv
// cordic_vec_stream_ctrl: credit-based sequencer feeding a fixed-latency CORDIC core and buffering its results.
// Optional CORDIC_CTRL_STATS_EN adds saturating accept/stall counters.
module cordic_vec_stream_ctrl
    import cordic_ctrl_pkg::*;
#(
    parameter int CORE_LAT   = 16,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                s_axis_tvalid,
    output logic                s_axis_tready,
    input  logic [TDATA_W-1:0]  s_axis_tdata,
    output logic                core_en,
    output logic [XY_W-1:0]     core_x,
    output logic [XY_W-1:0]     core_y,
    input  logic [AMP_W-1:0]    core_amp,
    input  logic [PH_W-1:0]     core_phase,
    output logic                m_axis_tvalid,
    input  logic                m_axis_tready,
    output logic [TDATA_W-1:0]  m_axis_tdata,
    output logic [15:0]         stat_in_cnt,
    output logic [15:0]         stat_stall_cnt
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic [CORE_LAT:0] r_vld;
    logic [CW-1:0]     r_inflight;
    logic              r_tready;
    logic              r_en;
    logic [XY_W-1:0]   r_x;
    logic [XY_W-1:0]   r_y;
    logic              w_acc;
    logic              w_push;
    logic              w_pop;
    logic              w_full;
    logic              w_empty;
    logic [CW-1:0]     w_count;
    logic [CW-1:0]     w_inflight_nxt;
    logic [CW-1:0]     w_count_nxt;
    logic [CW:0]       w_credit_used;
    result_t           w_core;
    result_t           w_head;

    assign w_acc  = s_axis_tvalid & r_tready;
    assign w_pop  = ~w_empty & m_axis_tready;
    assign w_push = r_vld[CORE_LAT] & (~w_full | w_pop);
    assign w_core = '{amp: core_amp, phase: core_phase};

    // Ready is precomputed from next-cycle occupancy so it never depends combinationally on m_axis_tready.
    always_comb begin
        w_inflight_nxt = r_inflight + CW'(w_acc) - CW'(w_push);
        w_count_nxt    = w_count + CW'(w_push) - CW'(w_pop);
        w_credit_used  = {1'b0, w_inflight_nxt} + {1'b0, w_count_nxt};
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_vld      <= '0;
            r_inflight <= '0;
            r_tready   <= 1'b0;
            r_en       <= 1'b0;
            r_x        <= '0;
            r_y        <= '0;
        end else begin
            r_vld      <= {r_vld[CORE_LAT-1:0], w_acc};
            r_inflight <= w_inflight_nxt;
            r_tready   <= w_credit_used < (CW+1)'(FIFO_DEPTH);
            r_en       <= w_acc;
            if (w_acc) {r_x, r_y} <= unpack_xy(s_axis_tdata);
        end
    end

    cordic_result_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .CLK     (CLK),
        .RST     (RST),
        .i_push  (w_push),
        .i_data  (w_core),
        .i_pop   (w_pop),
        .o_data  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    assign s_axis_tready = r_tready;
    assign core_en       = r_en;
    assign core_x        = r_x;
    assign core_y        = r_y;
    assign m_axis_tvalid = ~w_empty;
    assign m_axis_tdata  = w_empty ? '0 : pack_result(w_head);

`ifdef CORDIC_CTRL_STATS_EN
    logic [15:0] r_in_cnt;
    logic [15:0] r_stall_cnt;

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_in_cnt    <= '0;
            r_stall_cnt <= '0;
        end else begin
            if (w_acc && r_in_cnt != 16'hFFFF) r_in_cnt <= r_in_cnt + 16'd1;
            if (s_axis_tvalid && !r_tready && r_stall_cnt != 16'hFFFF) r_stall_cnt <= r_stall_cnt + 16'd1;
        end
    end

    assign stat_in_cnt    = r_in_cnt;
    assign stat_stall_cnt = r_stall_cnt;
`else
    assign stat_in_cnt    = 16'd0;
    assign stat_stall_cnt = 16'd0;
`endif
endmodule

// File: tb/tb_cordic_vec_stream_ctrl.sv
// tb_cordic_vec_stream_ctrl: scoreboard bench with a behavioural fixed-latency core model.
module tb_cordic_vec_stream_ctrl;
    localparam int L = 5;
    localparam int D = 8;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        s_axis_tvalid = 1'b0;
    logic        s_axis_tready;
    logic [31:0] s_axis_tdata = '0;
    logic        core_en;
    logic [11:0] core_x;
    logic [11:0] core_y;
    logic [11:0] core_amp;
    logic [13:0] core_phase;
    logic        m_axis_tvalid;
    logic        m_axis_tready = 1'b0;
    logic [31:0] m_axis_tdata;
    logic [15:0] stat_in_cnt;
    logic [15:0] stat_stall_cnt;

    always #5 CLK = ~CLK;

    cordic_vec_stream_ctrl #(.CORE_LAT(L), .FIFO_DEPTH(D)) dut (
        .CLK(CLK), .RST(RST),
        .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready), .s_axis_tdata(s_axis_tdata),
        .core_en(core_en), .core_x(core_x), .core_y(core_y),
        .core_amp(core_amp), .core_phase(core_phase),
        .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready), .m_axis_tdata(m_axis_tdata),
        .stat_in_cnt(stat_in_cnt), .stat_stall_cnt(stat_stall_cnt)
    );

    function automatic logic [11:0] f_amp(input logic [11:0] x, input logic [11:0] y);
        return x ^ {y[5:0], y[11:6]};
    endfunction

    function automatic logic [13:0] f_ph(input logic [11:0] x, input logic [11:0] y);
        return {y[6:0], x[6:0]} ^ 14'h2A5A;
    endfunction

    function automatic logic [31:0] expect_of(input logic [31:0] d);
        logic [11:0] x, y;
        x = d[27:16];
        y = d[11:0];
        return {4'd0, f_amp(x, y), 2'd0, f_ph(x, y)};
    endfunction

    // Core model: L-deep pipeline, never reset, emits junk when no sample is in that slot.
    logic [11:0] p_amp [L];
    logic [13:0] p_ph  [L];
    always @(posedge CLK) begin
        p_amp[0] <= core_en ? f_amp(core_x, core_y) : 12'($urandom);
        p_ph[0]  <= core_en ? f_ph(core_x, core_y) : 14'($urandom);
        for (int i = 1; i < L; i++) begin
            p_amp[i] <= p_amp[i-1];
            p_ph[i]  <= p_ph[i-1];
        end
    end
    assign core_amp   = p_amp[L-1];
    assign core_phase = p_ph[L-1];

    int          errors = 0;
    int          checks = 0;
    int          n_out = 0;
    int          m_in = 0;
    int          m_stall = 0;
    logic [31:0] q[$];
    logic        prev_stall = 1'b0;
    logic [31:0] prev_data = '0;

    // Scoreboard push on accept, pop/compare on every output handshake, hold check during stalls.
    always @(negedge CLK) begin
        logic [31:0] e;
        if (RST) begin
            q.delete();
            prev_stall = 1'b0;
            m_in = 0;
            m_stall = 0;
        end else begin
            if (s_axis_tvalid && s_axis_tready) begin
                q.push_back(expect_of(s_axis_tdata));
                if (m_in != 65535) m_in++;
            end
            if (s_axis_tvalid && !s_axis_tready && m_stall != 65535) m_stall++;
            if (prev_stall) begin
                checks++;
                if (!m_axis_tvalid || m_axis_tdata !== prev_data) begin
                    errors++;
                    $display("FAIL stall_hold: valid=%0b data=%h required valid=1 data=%h", m_axis_tvalid, m_axis_tdata, prev_data);
                end
            end
            if (m_axis_tvalid && m_axis_tready) begin
                checks++;
                n_out++;
                if (q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_output: data=%h with nothing outstanding", m_axis_tdata);
                end else begin
                    e = q.pop_front();
                    if (m_axis_tdata !== e) begin
                        errors++;
                        $display("FAIL result_order: got %h required %h", m_axis_tdata, e);
                    end
                end
            end
            prev_stall = m_axis_tvalid && !m_axis_tready;
            prev_data  = m_axis_tdata;
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h required %h", name, act, exp);
        end
    endtask

    task automatic chk_stats(input string tag);
`ifdef CORDIC_CTRL_STATS_EN
        chk({tag, "_stat_in"}, 32'(stat_in_cnt), 32'(m_in));
        chk({tag, "_stat_stall"}, 32'(stat_stall_cnt), 32'(m_stall));
`else
        chk({tag, "_stat_in"}, 32'(stat_in_cnt), 32'd0);
        chk({tag, "_stat_stall"}, 32'(stat_stall_cnt), 32'd0);
`endif
    endtask

    task automatic run(input int n, input int pv, input int pr, output int drops);
        int sent = 0;
        int g = 0;
        drops = 0;
        while (sent < n && g < 20000) begin
            s_axis_tvalid = $urandom_range(99) < pv;
            s_axis_tdata  = $urandom;
            m_axis_tready = $urandom_range(99) < pr;
            if (s_axis_tvalid && s_axis_tready) sent++;
            if (s_axis_tvalid && !s_axis_tready && sent > 0) drops++;
            tick();
            g++;
        end
        s_axis_tvalid = 1'b0;
        checks++;
        if (sent < n) begin
            errors++;
            $display("FAIL run_timeout: sent %0d required %0d", sent, n);
        end
    endtask

    task automatic drain();
        int g = 0;
        s_axis_tvalid = 1'b0;
        m_axis_tready = 1'b1;
        while ((q.size() != 0 || m_axis_tvalid) && g < 500) begin
            tick();
            g++;
        end
        checks++;
        if (g >= 500) begin
            errors++;
            $display("FAIL drain_timeout: outstanding %0d required 0", q.size());
        end
    endtask

    initial begin
        int n, o0, acc, drops;
        repeat (3) @(posedge CLK);
        #1;
        chk("rst_tready", 32'(s_axis_tready), 0);
        chk("rst_core_en", 32'(core_en), 0);
        chk("rst_core_xy", {8'd0, core_x, core_y}, 0);
        chk("rst_tvalid", 32'(m_axis_tvalid), 0);
        chk("rst_tdata", m_axis_tdata, 0);
        chk_stats("rst");
        RST = 1'b0;
        n = 0;
        while (!s_axis_tready && n < 10) begin
            tick();
            n++;
        end
        chk("tready_after_rst", 32'(s_axis_tready), 1);

        m_axis_tready = 1'b1;
        s_axis_tdata  = 32'h0300_0400;
        s_axis_tvalid = 1'b1;
        tick();
        s_axis_tvalid = 1'b0;
        chk("single_core_en", 32'(core_en), 1);
        chk("single_core_x", 32'(core_x), 32'h300);
        chk("single_core_y", 32'(core_y), 32'h400);
        tick();
        chk("single_core_en_off", 32'(core_en), 0);
        n = 2;
        while (!m_axis_tvalid && n < 60) begin
            tick();
            n++;
        end
        chk("single_latency", n, L + 2);
        chk("single_tdata", m_axis_tdata, expect_of(32'h0300_0400));
        drain();

        o0 = n_out;
        run(100, 100, 100, drops);
        chk("b2b_no_drop", drops, 0);
        drain();
        chk("b2b_count", n_out - o0, 100);
        chk_stats("b2b");

        m_axis_tready = 1'b0;
        s_axis_tvalid = 1'b1;
        acc = 0;
        o0 = n_out;
        for (int i = 0; i < 40; i++) begin
            s_axis_tdata = $urandom;
            if (s_axis_tready) acc++;
            tick();
        end
        chk("bp_accepts", acc, D);
        chk("bp_tready_low", 32'(s_axis_tready), 0);
        chk("bp_tvalid", 32'(m_axis_tvalid), 1);
        drain();
        chk("bp_count", n_out - o0, D);
        chk_stats("bp");

        o0 = n_out;
        run(1000, 50, 50, drops);
        drain();
        chk("rand_count", n_out - o0, 1000);
        chk_stats("rand");

        run(8, 100, 0, drops);
        tick();
        RST = 1'b1;
        tick();
        chk("mid_rst_tready", 32'(s_axis_tready), 0);
        chk("mid_rst_core_en", 32'(core_en), 0);
        chk("mid_rst_tvalid", 32'(m_axis_tvalid), 0);
        chk("mid_rst_tdata", m_axis_tdata, 0);
        chk_stats("mid_rst");
        RST = 1'b0;
        m_axis_tready = 1'b1;
        o0 = n_out;
        for (int i = 0; i < L + 4; i++) begin
            tick();
            chk("post_rst_quiet", 32'(m_axis_tvalid), 0);
        end
        chk("post_rst_no_output", n_out - o0, 0);

        o0 = n_out;
        run(20, 70, 70, drops);
        drain();
        chk("recover_count", n_out - o0, 20);
        chk_stats("recover");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
